// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder
// Byte-queue front end for the UART transmitter. Bytes from a producer are
// buffered in a circular FIFO and handed to the transmitter one at a time:
// each byte is placed on `data` with a one-cycle `tx_start` pulse, then the
// feeder waits for a rising edge on `tx_done` (or a watchdog expiry) and
// idles for GAP_CYCLES clocks before the next byte.
//
// Ports:
//   clk_3125    in   system clock (3.125 MHz)
//   rst         in   synchronous active-high reset
//   wr_en       in   producer write strobe
//   wr_data     in   byte to enqueue
//   full        out  FIFO holds DEPTH entries
//   empty       out  FIFO holds 0 entries
//   count       out  number of FIFO entries
//   tx_start    out  one-cycle start pulse to the transmitter
//   data        out  byte presented to the transmitter
//   tx_done     in   transmitter frame-complete level (rising edge used)
//   busy        out  high whenever the state is not IDLE
//   overflow    out  sticky, a write was dropped on a full FIFO
//   timeout_err out  sticky, a frame never completed
//   clr_err     in   clears overflow and timeout_err
module uart_tx_feeder #(
    parameter int DEPTH      = 8,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 1023
) (
    input  logic                     clk_3125,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     tx_start,
    output logic [7:0]               data,
    input  logic                     tx_done,
    output logic                     busy,
    output logic                     overflow,
    output logic                     timeout_err,
    input  logic                     clr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(GAP_CYCLES + 2);

    localparam logic [AW:0]   DEPTH_C     = (AW + 1)'(DEPTH);
    localparam logic [WW-1:0] WDOG_LAST   = WW'(TIMEOUT - 2);
    localparam logic [GW-1:0] GAP_LAST    = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        GAP
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_next;
    logic [WW-1:0] wdog;
    logic [GW-1:0] gap_cnt;
    logic          tx_done_q;
    logic          tx_rise;
    logic          pop;
    logic          push;
    logic          drop;
    logic          timeout_hit;

    assign tx_rise = tx_done & ~tx_done_q;

    // A write into a full FIFO still fits when the head is leaving in the
    // same cycle, since the freed slot is the one the write pointer sits on.
    assign push = wr_en & (~full | pop);
    assign drop = wr_en & full & ~pop;

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + (AW + 1)'(1);
            2'b01:   count_next = count - (AW + 1)'(1);
            default: count_next = count;
        endcase
    end

    // Next-state logic. The watchdog is compared one short of TIMEOUT-1 so
    // the error flag lands on the edge where the count would reach TIMEOUT-1.
    // A frame completion beats a simultaneous watchdog expiry.
    always_comb begin
        state_next  = state;
        pop         = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (tx_rise) begin
                    state_next = (GAP_CYCLES == 0) ? IDLE : GAP;
                end else if (wdog == WDOG_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = (GAP_CYCLES == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FIFO storage has no reset; the pointers alone define its contents.
    always_ff @(posedge clk_3125) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // State register, FIFO bookkeeping, counters and sticky error flags.
    always_ff @(posedge clk_3125) begin
        if (rst) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            full        <= 1'b0;
            empty       <= 1'b1;
            tx_start    <= 1'b0;
            data        <= 8'h00;
            busy        <= 1'b0;
            overflow    <= 1'b0;
            timeout_err <= 1'b0;
            tx_done_q   <= 1'b0;
            wdog        <= '0;
            gap_cnt     <= '0;
        end else begin
            state     <= state_next;
            busy      <= (state_next != IDLE);
            tx_done_q <= tx_done;
            tx_start  <= pop;

            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                data   <= mem[rd_ptr];
            end
            count <= count_next;
            full  <= (count_next == DEPTH_C);
            empty <= (count_next == '0);

            if (state == START) begin
                wdog <= '0;
            end else if (state == WAIT) begin
                wdog <= wdog + WW'(1);
            end

            if (state == GAP) begin
                gap_cnt <= gap_cnt + GW'(1);
            end else begin
                gap_cnt <= '0;
            end

            // A new error event wins over a clear in the same cycle.
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end

            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end else if (clr_err) begin
                timeout_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder
// Scoreboard bench for uart_tx_feeder. Accepted bytes are queued as they are
// written; a monitor pops and compares on every tx_start. A transmitter model
// answers each start with a tx_done pulse after a configurable delay.
module tb_uart_tx_feeder;

    localparam int DEPTH      = 8;
    localparam int GAP_CYCLES = 2;
    localparam int TIMEOUT    = 1023;

    logic                   clk_3125 = 1'b0;
    logic                   rst      = 1'b1;
    logic                   wr_en    = 1'b0;
    logic [7:0]             wr_data  = 8'h00;
    logic                   tx_done  = 1'b0;
    logic                   clr_err  = 1'b0;
    logic                   full;
    logic                   empty;
    logic [$clog2(DEPTH):0] count;
    logic                   tx_start;
    logic [7:0]             data;
    logic                   busy;
    logic                   overflow;
    logic                   timeout_err;

    int         checks         = 0;
    int         errors         = 0;
    int         cyc            = 0;
    logic [7:0] exp_q[$];
    int         start_count    = 0;
    int         last_start_cyc = -1;
    logic       prev_tx_start  = 1'b0;
    int         rise_cyc       = 0;
    bit         rise_valid     = 1'b0;
    bit         chk_gap        = 1'b0;
    bit         tx_model_en    = 1'b0;
    int         tx_delay       = 20;

    uart_tx_feeder #(
        .DEPTH      (DEPTH),
        .GAP_CYCLES (GAP_CYCLES),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk_3125    (clk_3125),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .tx_start    (tx_start),
        .data        (data),
        .tx_done     (tx_done),
        .busy        (busy),
        .overflow    (overflow),
        .timeout_err (timeout_err),
        .clr_err     (clr_err)
    );

    always #5 clk_3125 = ~clk_3125;

    // Edge index: after posedge k, cyc == k.
    always @(posedge clk_3125) cyc++;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    // Drives one cycle of inputs starting at a negedge; accepted writes are
    // pushed to the scoreboard before the sampling edge.
    task automatic applyStimulus(input logic we, input logic [7:0] d,
                                 input logic ce, input bit accept);
        wr_en   = we;
        wr_data = d;
        clr_err = ce;
        if (we && accept) exp_q.push_back(d);
        @(negedge clk_3125);
        wr_en   = 1'b0;
        clr_err = 1'b0;
    endtask

    task automatic waitDrain(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            @(negedge clk_3125);
            n++;
        end
        checkOutput(name, 32'(n < budget), 32'd1);
    endtask

    // Scoreboard monitor: every start pulse must carry the next queued byte.
    always @(negedge clk_3125) begin
        if (tx_start) begin
            checkOutput("tx_start_one_cycle", 32'(prev_tx_start), 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_tx_start: data %02h, none expected", data);
            end else begin
                checkOutput("tx_data", 32'(data), 32'(exp_q.pop_front()));
            end
            if (chk_gap && rise_valid)
                checkOutput("start_after_rise", 32'(cyc), 32'(rise_cyc + GAP_CYCLES + 2));
            rise_valid     = 1'b0;
            start_count++;
            last_start_cyc = cyc;
        end
        prev_tx_start = tx_start;
    end

    // Transmitter model: tx_done rises tx_delay cycles after a start.
    initial begin
        forever begin
            @(negedge clk_3125);
            if (tx_start && tx_model_en) begin
                repeat (tx_delay) @(negedge clk_3125);
                tx_done    = 1'b1;
                rise_cyc   = cyc;
                rise_valid = 1'b1;
                repeat (2) @(negedge clk_3125);
                tx_done = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL global_timeout: simulation still running at cycle %0d, expected to finish", cyc);
        $fatal(1, "[TB] simulation aborted");
    end

    initial begin
        logic [7:0] parth [5];
        int wr_cyc;
        int s0;
        int n;
        int t_start;
        int exp_cnt;

        parth = '{8'h50, 8'h61, 8'h72, 8'h74, 8'h48};

        // Reset state
        repeat (3) @(negedge clk_3125);
        checkOutput("rst_busy",        32'(busy),        32'd0);
        checkOutput("rst_count",       32'(count),       32'd0);
        checkOutput("rst_empty",       32'(empty),       32'd1);
        checkOutput("rst_full",        32'(full),        32'd0);
        checkOutput("rst_tx_start",    32'(tx_start),    32'd0);
        checkOutput("rst_data",        32'(data),        32'd0);
        checkOutput("rst_overflow",    32'(overflow),    32'd0);
        checkOutput("rst_timeout_err", 32'(timeout_err), 32'd0);
        rst = 1'b0;
        @(negedge clk_3125);

        // Single byte with a slow transmitter
        $display("[TB] single byte, tx_done after 300 cycles");
        tx_model_en = 1'b1;
        tx_delay    = 300;
        s0          = start_count;
        wr_cyc      = cyc;
        applyStimulus(1'b1, 8'h50, 1'b0, 1'b1);
        n = 0;
        while (!busy && n < 10) begin
            @(negedge clk_3125);
            n++;
        end
        checkOutput("single_busy_rise_bound", 32'(n < 10), 32'd1);
        n = 0;
        while (busy && n < 1000) begin
            @(negedge clk_3125);
            n++;
        end
        checkOutput("single_busy_fall_bound", 32'(n < 1000), 32'd1);
        checkOutput("single_busy_fall_cycle", 32'(cyc), 32'(rise_cyc + GAP_CYCLES + 1));
        checkOutput("single_start_count", 32'(start_count - s0), 32'd1);
        checkOutput("single_start_latency", 32'(last_start_cyc), 32'(wr_cyc + 2));

        // Burst "PartH" back-to-back
        $display("[TB] burst PartH");
        tx_delay   = 20;
        rise_valid = 1'b0;
        chk_gap    = 1'b1;
        s0         = start_count;
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, parth[i], 1'b0, 1'b1);
        waitDrain("burst_drain", 2000);
        chk_gap = 1'b0;
        checkOutput("burst_start_count", 32'(start_count - s0), 32'd5);
        checkOutput("burst_overflow",    32'(overflow),         32'd0);

        // Ten writes with tx_done stuck low: one pops, eight queue, one drops
        $display("[TB] overflow and timeout");
        tx_model_en = 1'b0;
        rise_valid  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 8'(8'h10 + i), 1'b0, i < 9);
            exp_cnt = (i < 2) ? 1 : ((i > 8) ? 8 : i);
            checkOutput("ovf_count",    32'(count),    32'(exp_cnt));
            checkOutput("ovf_full",     32'(full),     32'(i >= 8));
            checkOutput("ovf_overflow", 32'(overflow), 32'(i == 9));
        end
        t_start = last_start_cyc;

        // Dropped write together with clr_err: the set wins
        applyStimulus(1'b1, 8'hEE, 1'b1, 1'b0);
        checkOutput("ovf_set_beats_clr", 32'(overflow), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("ovf_cleared", 32'(overflow), 32'd0);

        while (cyc < t_start + TIMEOUT - 1) @(negedge clk_3125);
        checkOutput("timeout_not_early", 32'(timeout_err), 32'd0);
        @(negedge clk_3125);
        checkOutput("timeout_set", 32'(timeout_err), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("timeout_cleared", 32'(timeout_err), 32'd0);

        // Write while full in the cycle the IDLE pop happens
        s0 = start_count;
        n  = 0;
        while (busy && n < 10) begin
            @(negedge clk_3125);
            n++;
        end
        checkOutput("gap_to_idle_bound", 32'(n < 10), 32'd1);
        checkOutput("full_before_pop",   32'(full),   32'd1);
        tx_model_en = 1'b1;
        tx_delay    = 10;
        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b1);
        checkOutput("pop_write_count",    32'(count),    32'(DEPTH));
        checkOutput("pop_write_full",     32'(full),     32'd1);
        checkOutput("pop_write_overflow", 32'(overflow), 32'd0);
        waitDrain("full_drain", 3000);
        checkOutput("full_drain_starts", 32'(start_count - s0), 32'd9);

        // Reset during WAIT with three bytes queued
        $display("[TB] reset mid-frame");
        tx_delay = 50;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'hC0 + i), 1'b0, 1'b1);
        repeat (10) @(negedge clk_3125);
        checkOutput("pre_rst_count", 32'(count), 32'd3);
        checkOutput("pre_rst_busy",  32'(busy),  32'd1);
        rst = 1'b1;
        @(negedge clk_3125);
        rst = 1'b0;
        exp_q.delete();
        checkOutput("mid_rst_busy",     32'(busy),     32'd0);
        checkOutput("mid_rst_count",    32'(count),    32'd0);
        checkOutput("mid_rst_tx_start", 32'(tx_start), 32'd0);
        checkOutput("mid_rst_empty",    32'(empty),    32'd1);
        s0 = start_count;
        repeat (200) @(negedge clk_3125);
        checkOutput("no_start_after_rst", 32'(start_count - s0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_feeder.md
# uart_tx_feeder

Byte-queue front end for the UART transmitter. It buffers bytes from a producer in a small circular FIFO and hands them to the transmitter one at a time. For each byte it drives the transmitter's `data` bus and a one-cycle `tx_start` pulse, then waits for `tx_done` before issuing the next byte. A watchdog flags a transmitter that never completes a frame, and a sticky flag records bytes dropped on a full queue.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; must be a power of two, at least 2.
- `GAP_CYCLES`, 2: idle clocks inserted after each frame completes, before the next `tx_start`; 0 is allowed.
- `TIMEOUT`, 1023: maximum clocks spent in WAIT before a timeout is declared; must be at least 2.

Ports:
- `clk_3125`  in  1  system clock, 3.125 MHz.
- `rst`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  producer write strobe.
- `wr_data`  in  8  byte to enqueue.
- `full`  out  1  FIFO holds `DEPTH` entries.
- `empty`  out  1  FIFO holds 0 entries.
- `count`  out  clog2(DEPTH)+1  current number of FIFO entries.
- `tx_start`  out  1  one-cycle start pulse to the transmitter.
- `data`  out  8  byte presented to the transmitter.
- `tx_done`  in  1  transmitter frame-complete signal; treated as a level, and its rising edge is used.
- `busy`  out  1  high whenever the state is not IDLE.
- `overflow`  out  1  sticky; set when a write is dropped.
- `timeout_err`  out  1  sticky; set when a frame times out.
- `clr_err`  in  1  clears `overflow` and `timeout_err`.

## Operation
- All outputs and state are registered on `clk_3125`.
- Reset values (`rst`=1):
  - State is IDLE and the FIFO pointers and `count` are 0.
  - `empty`=1, `full`=0.
  - `tx_start`=0, `data`=8'h00, `busy`=0, `overflow`=0, `timeout_err`=0.
  - The internal `tx_done_q` register is 0 and the counters are 0.
- `rst` overrides every other input in the same cycle, including while a frame is in progress. Queued bytes are discarded.
- FIFO write rule:
  - `wr_en` is accepted when `!full`, or when a pop occurs in the same cycle. In that case `count` is unchanged and the write pointer advances.
  - A write with `wr_en` while full and no pop is dropped, and `overflow` is set on the next edge.
- Pointers wrap modulo `DEPTH`.
- Rising-edge detect: `tx_rise = tx_done & ~tx_done_q`, with `tx_done_q` registered every cycle.
- State machine:
  - **IDLE**: if `!empty`, pop the head entry into `data`, set `tx_start`=1, and go to START.
  - **START**: lasts exactly one cycle. Clear `tx_start`, clear the watchdog, and go to WAIT.
  - **WAIT**: the watchdog increments each cycle.
    - On `tx_rise`, go to GAP.
    - Otherwise, when the watchdog reaches `TIMEOUT-1`, set `timeout_err` and go to GAP.
    - `tx_rise` takes priority over timeout in the same cycle.
  - **GAP**: count `GAP_CYCLES` clocks, then go to IDLE. If `GAP_CYCLES`=0, go from WAIT straight to IDLE.
- `data` holds its value from the pop until the next pop. It is never changed while in START, WAIT or GAP.
- `tx_rise` is ignored outside WAIT.
- `clr_err` and a new error event in the same cycle: the set wins.
- `overflow` is independent of state; writes are accepted in every state.

## Timing
- A write sampled at edge k into an empty, idle FIFO: at edge k+1 `data` is valid and `tx_start`=1; at edge k+2 `tx_start`=0.
- `tx_start` is high for exactly one cycle per byte. `data` is stable on the cycle `tx_start` is high.
- Next `tx_start`: `tx_rise` seen at edge m gives the next `tx_start` high at edge m+GAP_CYCLES+2, provided a byte is queued.
- Timeout: WAIT is entered at edge s, and `timeout_err` is set at edge s+TIMEOUT-1 (TIMEOUT−1 clocks after entering WAIT).
- `count`, `full` and `empty` update on the edge after the write or pop.

## Test plan
- Reset mid-frame: assert `rst` for 1 cycle during WAIT with 3 bytes queued → next cycle `busy`=0, `count`=0, `tx_start`=0, and no further `tx_start` occurs.
- Single byte 8'h50 with a transmitter model returning `tx_done` 300 cycles after start → exactly one `tx_start` pulse with `data`=8'h50; `busy` returns to 0 GAP_CYCLES+1 clocks after the `tx_done` rise.
- Burst of "PartH" (8'h50, 8'h61, 8'h72, 8'h74, 8'h48) written on back-to-back cycles → five `tx_start` pulses in order, each issued only after the previous `tx_done` rise; `overflow`=0.
- Write 10 bytes back-to-back with `DEPTH`=8 and `tx_done` held low → the first byte pops, 8 more are queued, and the 10th is dropped; `overflow`=1 and `full`=1.
- `tx_done` stuck low → `timeout_err`=1 exactly TIMEOUT−1 clocks after entering WAIT; the next byte still issues; `clr_err` returns the flag to 0.
- Write while full in the same cycle as the IDLE pop → write accepted, `count` stays at `DEPTH`, `overflow` stays 0.
